// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// master: the requester (drives start and operands); slave: the divider.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// IDLE -> CALC (WIDTH iterations) -> DONE (one-cycle done pulse) -> IDLE.
// A zero divisor skips CALC and reports in DONE after a single cycle.
// Optional build macro SEQ_DIVIDER_SIGNED_EN: two's complement operands,
// truncating division, sign fix-up applied when the outputs are loaded.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          clr,
  seq_divider_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd;       // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] dvs;       // divisor magnitude
  logic [WIDTH:0]   rem;       // partial remainder, one extra bit of headroom
  logic [WIDTH-1:0] quo;       // quotient bits as they are produced
  logic [5:0]       cnt;       // iteration counter
  logic [WIDTH-1:0] q_out, r_out;
  logic             dz;

  logic [WIDTH:0]   shifted, rem_nxt;
  logic [WIDTH-1:0] quo_nxt, q_fix, r_fix;
  logic             ge;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic q_neg, r_neg;
  // Magnitudes of the incoming operands; the most-negative value maps to
  // 2**(WIDTH-1), which still fits the unsigned core.
  always_comb begin
    a_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    b_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    q_fix = q_neg ? -quo_nxt : quo_nxt;
    r_fix = r_neg ? -rem_nxt[WIDTH-1:0] : rem_nxt[WIDTH-1:0];
  end

  // Capture the result signs at the accepting edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      r_neg <= bus.dividend[WIDTH-1];
    end
  end
`else
  // Unsigned: operands pass straight through, no sign handling.
  always_comb begin
    a_mag = bus.dividend;
    b_mag = bus.divisor;
    q_fix = quo_nxt;
    r_fix = rem_nxt[WIDTH-1:0];
  end
`endif

  // One restoring iteration: shift in the next dividend bit, trial-subtract.
  always_comb begin
    shifted = {rem[WIDTH-1:0], dvd[WIDTH-1]};
    ge      = (shifted >= {1'b0, dvs});
    rem_nxt = ge ? (shifted - {1'b0, dvs}) : shifted;
    quo_nxt = {quo[WIDTH-2:0], ge};
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      q_out <= '0;
      r_out <= '0;
      dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          dvd <= a_mag;
          dvs <= b_mag;
          rem <= '0;
          quo <= '0;
          cnt <= '0;
          dz  <= 1'b0;
          if (bus.divisor == '0) begin
            // Result is fixed: all-ones quotient, dividend back as remainder.
            q_out <= '1;
            r_out <= bus.dividend;
            dz    <= 1'b1;
            state <= DONE;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], 1'b0};
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 6'd1;
          if (cnt == 6'(WIDTH - 1)) begin
            q_out <= q_fix;
            r_out <= r_fix;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (state == CALC);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): the stimulus pushes expected
// {quotient, remainder, div_by_zero}; a monitor pops on every done pulse.
module tb_seq_divider;
  localparam int W = 4;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus();
  seq_divider #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  logic [2*W:0] sb[$];
  int n_vec  = 0;
  int n_miss = 0;
  int n_done = 0;

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!clr && bus.done) begin
      logic [2*W:0] got, exp;
      n_done++;
      got = {bus.quotient, bus.remainder, bus.div_by_zero};
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL result: unexpected done, got q=%0d r=%0d dz=%0b",
                 got[2*W:W+1], got[W:1], got[0]);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          n_miss++;
          $display("FAIL result: got q=%b r=%b dz=%b, want q=%b r=%b dz=%b",
                   got[2*W:W+1], got[W:1], got[0], exp[2*W:W+1], exp[W:1], exp[0]);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Raise start now (caller is just past a posedge), drop it after the next edge.
  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dz, input bit push);
    #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    if (push) sb.push_back({q, r, dz});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // From just after the accepting edge: count busy cycles and done latency.
  task automatic measure(input string name, input int exp_busy, input int exp_lat);
    int bc = 0;
    int lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin lat = k; break; end
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " busy cycles"}, bc, exp_busy);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int d0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #2;
    check("reset q", bus.quotient, 0);
    check("reset r", bus.remainder, 0);
    check("reset flags", {bus.busy, bus.done, bus.div_by_zero}, 0);
    idle(2); #1 clr = 1'b0;
    idle(2);

`ifdef SEQ_DIVIDER_SIGNED_EN
    do_start(4'b1001, 4'd2, 4'b1101, 4'b1111, 1'b0, 1); measure("-7/2", W, W + 1);
    idle(1);
    do_start(4'b1000, 4'b1111, 4'b1000, 4'd0, 1'b0, 1); measure("-8/-1", W, W + 1);
    idle(1);
    do_start(4'd7, 4'b1110, 4'b1101, 4'd1, 1'b0, 1); measure("7/-2", W, W + 1);
    idle(1);
    do_start(4'b1101, 4'd0, 4'b1111, 4'b1101, 1'b1, 1); measure("-3/0", 0, 1);
    idle(1);
`else
    do_start(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1); measure("13/3", W, W + 1);
    idle(1);
    // Back-to-back: second start in the first IDLE cycle after done.
    do_start(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1); measure("15/1", W, W + 1);
    @(posedge clk);
    do_start(4'd3, 4'd5, 4'd0, 4'd3, 1'b0, 1); measure("3/5 b2b", W, W + 1);
    idle(1);
    do_start(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1); measure("7/0", 0, 1);
    idle(1);
    do_start(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1); measure("9/2", W, W + 1);
    idle(1);
    // Extra start and operand change during CALC are ignored.
    d0 = n_done;
    do_start(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1);
    @(posedge clk);
    do_start(4'd1, 4'd1, 4'd0, 4'd0, 1'b0, 0);
    bus.dividend = 4'd8; bus.divisor = 4'd7;
    idle(W + 4);
    check("14/4 done pulses", n_done - d0, 1);
    // Asynchronous clr mid-CALC aborts without a done pulse.
    d0 = n_done;
    do_start(4'd11, 4'd2, 4'd0, 4'd0, 1'b0, 0);
    idle(2); #3;
    clr = 1'b1; #1;
    check("abort q", bus.quotient, 0);
    check("abort r", bus.remainder, 0);
    check("abort flags", {bus.busy, bus.done, bus.div_by_zero}, 0);
    idle(1); #1 clr = 1'b0;
    idle(W + 3);
    check("abort done pulses", n_done - d0, 0);
    @(posedge clk);
    do_start(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 1); measure("11/2", W, W + 1);
    idle(1);
`endif
    idle(3);
    check("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring shift-subtract divider, the inverse operation of the team's shift-add sequential multiplier.
- Divides an unsigned WIDTH-bit dividend by a WIDTH-bit divisor.
- Produces one quotient bit per clock.
- Contains its own control FSM with a start/busy/done handshake, so the top level needs no external sequencer.
- Sits beside the multiplier in the arithmetic datapath; same operand width convention.

Parameters:
WIDTH, 4, operand, quotient and remainder width in bits (legal: 2..32)

Ports:
clk  input  1  system clock; all state changes on the rising edge
clr  input  1  reset, asynchronous, active-high; forces IDLE and clears all registers
start  input  1  request a division; sampled only in IDLE
dividend  input  WIDTH  dividend; sampled at the edge where start is accepted
divisor  input  WIDTH  divisor; sampled at the edge where start is accepted
quotient  output  WIDTH  registered quotient; valid from the done cycle, held until the next accepted start
remainder  output  WIDTH  registered remainder; same validity as quotient
busy  output  1  high while the state is CALC
done  output  1  one-cycle pulse; results are valid
div_by_zero  output  1  registered flag; set with done when divisor was 0, cleared on the next accepted start

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE; quotient, remainder, busy, done, div_by_zero and all internal registers = 0.
- Reset asserted mid-operation aborts the division immediately. No done pulse is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 at an edge (E0): latch the operands, clear div_by_zero and bit counter.
  - divisor!=0 -> go to CALC.
  - divisor==0 -> go directly to DONE.
  - start=0 -> stay in IDLE.
- CALC: runs exactly WIDTH iterations, one per edge (E1..E_WIDTH). Each iteration:
  - Shift the partial remainder left by 1, taking the next dividend MSB in.
  - Trial-subtract the divisor.
  - If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - The partial remainder is WIDTH+1 bits internally so no overflow is possible.
  - At E_WIDTH: load quotient/remainder outputs and go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE.
  - start is ignored in DONE and in CALC; no queuing.
- Latency: start accepted at E0 -> done high in the cycle after E_WIDTH (WIDTH cycles later).
  - busy is high for exactly WIDTH cycles.
  - Back-to-back operation: a new start is accepted no earlier than the IDLE cycle following done, so the minimum period is WIDTH+2 cycles.
- Divide by zero: done is high in the cycle after E0 (latency 1), with quotient = all ones, remainder = dividend, div_by_zero=1. busy is never asserted.
- Operand changes after the accepting edge have no effect.
- Outputs keep the last result through IDLE and are updated only when DONE is entered.
- Invariant (divisor!=0): dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
SEQ_DIVIDER_SIGNED_EN
- Defined:
  - Operands are two's complement. The magnitudes are divided by the same unsigned core.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend (truncating division).
  - Sign fix-up happens when loading outputs at E_WIDTH, so latency is unchanged.
  - Most-negative / -1 wraps: quotient = most-negative, remainder = 0.
  - Divide by zero gives quotient = all ones, remainder = dividend.
- Undefined: purely unsigned as described above; no sign logic is synthesized.

Test Plan:
- WIDTH=4, start with 13/3 -> busy high 4 cycles, done pulse 4 cycles after the accepting edge, quotient=4, remainder=1, div_by_zero=0.
- 15/1, then 3/5 back-to-back, start issued in the first IDLE cycle after done -> 15 r0, then 0 r3; the second start is accepted.
- 7/0 -> done high the cycle after the accepting edge, busy never high, quotient=15, remainder=7, div_by_zero=1; next division 9/2 clears div_by_zero and gives 4 r1.
- Start 14/4, pulse start again and change operands during CALC -> extra start ignored, result 3 r2, exactly one done pulse.
- Start 11/2, assert clr asynchronously after 2 CALC cycles -> all outputs 0 immediately, no done pulse; a later 11/2 gives 5 r1.
- SEQ_DIVIDER_SIGNED_EN, WIDTH=4: -7/2 -> quotient 4'b1101 (-3), remainder 4'b1111 (-1); -8/-1 -> quotient 4'b1000, remainder 0.
